bp_cce_cfg_cmd_arbiter: RTL

//  Shares one config-network command/response channel (io_cmd/io_resp, bp_cce_mem_msg_s)

---
 rtl/bp_me_pkg.sv | 12 +
 rtl/bsg_fifo_1r1w_small.sv | 51 +++++
 rtl/bp_cce_cfg_cmd_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bp_me_pkg.sv
// Shared memory-engine types: config-command arbiter FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_arb_idle,
    e_arb_grant,
    e_arb_locked
  } bp_cfg_arb_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register FIFO, one write and one read port, head visible when v_o.
// Latency: 1 cycle write-to-read.
// Backpressure: none internally; caller must not push when full.
module bsg_fifo_1r1w_small #(
  parameter int els_p   = 8,
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0]   wptr_r, rptr_r;
  logic [cnt_w-1:0]   count_r;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (v_i)    wptr_r <= ptr_inc(wptr_r);
      if (yumi_i) rptr_r <= ptr_inc(rptr_r);
      case ({v_i, yumi_i})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (v_i) mem_r[wptr_r] <= data_i;
  end

  assign v_o    = (count_r != '0);
  assign data_o = mem_r[rptr_r];

endmodule

// File: rtl/bp_cce_cfg_cmd_arbiter.sv
// Round-robin share of one cfg cmd/resp channel among requesters, with grant lock and credit tracking.
// Latency: 1 cycle arbitration before io_cmd_v_o; responses routed combinationally.
// Backpressure: cmd held until io_cmd_yumi_i; resp stalls on the owning requester's ready.
module bp_cce_cfg_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_req_p     = 2,
  parameter int msg_width_p   = 32,
  parameter int max_credits_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  input  logic [num_req_p-1:0]             req_lock_i,
  output logic [num_req_p-1:0]             req_cmd_yumi_o,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_yumi_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_ready_o,
  output logic [msg_width_p-1:0]           req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_ready_i,
  output logic                             idle_o,
  output logic                             err_o
);

  localparam int id_w   = $clog2(num_req_p);
  localparam int cred_w = $clog2(max_credits_p + 1);

  bp_cfg_arb_state_e state_r;
  logic [id_w-1:0]   grant_r, rr_r, rr_next, pick_id, head_id;
  logic [cred_w-1:0] credits_r;
  logic              pick_v, cmd_fire, resp_fire, fifo_v, err_r;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    int idx;
    idx     = 0;
    pick_v  = 1'b0;
    pick_id = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      idx = (int'(rr_r) + i) % num_req_p;
      if (req_cmd_v_i[idx]) begin
        pick_v  = 1'b1;
        pick_id = id_w'(idx);
      end
    end
  end

  assign rr_next    = (grant_r == id_w'(num_req_p - 1)) ? '0 : grant_r + id_w'(1);
  assign io_cmd_o   = req_cmd_i[grant_r*msg_width_p +: msg_width_p];
  assign io_cmd_v_o = (state_r != e_arb_idle) & req_cmd_v_i[grant_r]
                    & (credits_r < cred_w'(max_credits_p));
  assign cmd_fire   = io_cmd_v_o & io_cmd_yumi_i;

  always_comb begin
    req_cmd_yumi_o          = '0;
    req_cmd_yumi_o[grant_r] = cmd_fire;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_arb_idle;
      grant_r <= '0;
      rr_r    <= '0;
    end else begin
      case (state_r)
        e_arb_idle: begin
          if (pick_v) begin
            grant_r <= pick_id;
            state_r <= e_arb_grant;
          end
        end
        e_arb_grant, e_arb_locked: begin
          if (cmd_fire) begin
            rr_r    <= rr_next;
            state_r <= req_lock_i[grant_r] ? e_arb_locked : e_arb_idle;
          end else if (!req_cmd_v_i[grant_r]) begin
            // A locked owner may idle between messages while still holding the lock.
            if (state_r == e_arb_grant || !req_lock_i[grant_r])
              state_r <= e_arb_idle;
          end
        end
        default: state_r <= e_arb_idle;
      endcase
    end
  end

  bsg_fifo_1r1w_small #(
    .els_p  (max_credits_p),
    .width_p(id_w)
  ) route_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   (grant_r),
    .v_i      (cmd_fire),
    .v_o      (fifo_v),
    .data_o   (head_id),
    .yumi_i   (resp_fire)
  );

  assign io_resp_ready_o = ~fifo_v | req_resp_ready_i[head_id];
  assign resp_fire       = io_resp_v_i & io_resp_ready_o & fifo_v;
  assign req_resp_o      = io_resp_i;

  always_comb begin
    req_resp_v_o          = '0;
    req_resp_v_o[head_id] = io_resp_v_i & fifo_v;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credits_r <= '0;
      err_r     <= 1'b0;
    end else begin
      case ({cmd_fire, resp_fire})
        2'b10:   credits_r <= credits_r + cred_w'(1);
        2'b01:   credits_r <= credits_r - cred_w'(1);
        default: credits_r <= credits_r;
      endcase
      if (io_resp_v_i & ~fifo_v) err_r <= 1'b1;
    end
  end

  assign err_o  = err_r;
  assign idle_o = (credits_r == '0) & (state_r == e_arb_idle) & ~|req_cmd_v_i;

endmodule
